// File: rtl/intersection_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intersection_controller : NS/EW phase sequencer with emergency preemption,
// all-red clearance and resume. Optional PED_WALK_EN adds ns_walk/ew_walk.
// Revision 1.0
// ---------------------------------------------------------------------------
module intersection_controller #(
  parameter int LEFT_CYC   = 5,
  parameter int GREEN_CYC  = 10,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int CW         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       emergency,
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic [3:0] phase,
  output logic       preempt_active
`ifdef PED_WALK_EN
  ,
  output logic       ns_walk,
  output logic       ew_walk
`endif
);

  typedef enum logic [3:0] {
    NS_LEFT   = 4'd0,
    NS_GREEN  = 4'd1,
    NS_YELLOW = 4'd2,
    ALLRED_A  = 4'd3,
    EW_LEFT   = 4'd4,
    EW_GREEN  = 4'd5,
    EW_YELLOW = 4'd6,
    ALLRED_B  = 4'd7,
    PREEMPT   = 4'd8
  } state_t;

  localparam logic [CW-1:0] L_M1 = CW'(LEFT_CYC - 1);
  localparam logic [CW-1:0] G_M1 = CW'(GREEN_CYC - 1);
  localparam logic [CW-1:0] Y_M1 = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] A_M1 = CW'(ALLRED_CYC - 1);

  state_t        state, n_state, save_state, n_save_state;
  logic [CW-1:0] cnt, n_cnt, save_cnt, n_save_cnt;
  logic          forced, n_forced, pend, n_pend, post, n_post, clr_ew, n_clr_ew;
  logic          cnt_zero, is_ew;

  assign cnt_zero = (cnt == '0);
  assign is_ew    = state[2];

  function automatic logic [3:0] ns_lamp(input state_t s);
    case (s)
      NS_LEFT:   ns_lamp = 4'b1001;
      NS_GREEN:  ns_lamp = 4'b0100;
      NS_YELLOW: ns_lamp = 4'b0010;
      default:   ns_lamp = 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] ew_lamp(input state_t s);
    case (s)
      EW_LEFT:   ew_lamp = 4'b1001;
      EW_GREEN:  ew_lamp = 4'b0100;
      EW_YELLOW: ew_lamp = 4'b0010;
      default:   ew_lamp = 4'b0001;
    endcase
  endfunction

  always_comb begin
    n_state      = state;
    n_cnt        = cnt_zero ? cnt : cnt - 1'b1;
    n_save_state = save_state;
    n_save_cnt   = save_cnt;
    n_forced     = forced;
    n_pend       = pend;
    n_post       = post;
    n_clr_ew     = clr_ew;
    case (state)
      NS_LEFT, NS_GREEN, EW_LEFT, EW_GREEN: begin
        if (emergency) begin
          // Resume later with only the cycles left after this one.
          n_save_state = state;
          n_save_cnt   = cnt_zero ? '0 : cnt - 1'b1;
          n_state      = is_ew ? EW_YELLOW : NS_YELLOW;
          n_cnt        = Y_M1;
          n_forced     = 1'b1;
          n_clr_ew     = is_ew;
        end else if (cnt_zero) begin
          if (state == NS_LEFT || state == EW_LEFT) begin
            n_state = is_ew ? EW_GREEN : NS_GREEN;
            n_cnt   = G_M1;
          end else begin
            n_state = is_ew ? EW_YELLOW : NS_YELLOW;
            n_cnt   = Y_M1;
          end
        end
      end
      NS_YELLOW, EW_YELLOW: begin
        if (cnt_zero) begin
          if (forced || pend || emergency) begin
            n_state  = PREEMPT;
            n_cnt    = '0;
            n_forced = 1'b0;
            n_pend   = 1'b0;
            if (!forced) begin
              n_save_state = is_ew ? NS_LEFT : EW_LEFT;
              n_save_cnt   = L_M1;
              n_clr_ew     = is_ew;
            end
          end else begin
            n_state = is_ew ? ALLRED_B : ALLRED_A;
            n_cnt   = A_M1;
          end
        end else if (emergency && !forced) begin
          n_pend = 1'b1;
        end
      end
      ALLRED_A, ALLRED_B: begin
        if (post) begin
          // Post-preempt clearance: only the final edge looks at emergency.
          if (cnt_zero) begin
            n_post = 1'b0;
            if (emergency) begin
              n_state = PREEMPT;
              n_cnt   = '0;
            end else begin
              n_state = save_state;
              n_cnt   = save_cnt;
            end
          end
        end else if (emergency) begin
          n_state      = PREEMPT;
          n_cnt        = '0;
          n_save_state = is_ew ? NS_LEFT : EW_LEFT;
          n_save_cnt   = L_M1;
          n_clr_ew     = is_ew;
        end else if (cnt_zero) begin
          n_state = is_ew ? NS_LEFT : EW_LEFT;
          n_cnt   = L_M1;
        end
      end
      PREEMPT: begin
        n_cnt = '0;
        if (!emergency) begin
          n_state = clr_ew ? ALLRED_B : ALLRED_A;
          n_cnt   = A_M1;
          n_post  = 1'b1;
        end
      end
      default: begin
        n_state = NS_LEFT;
        n_cnt   = L_M1;
      end
    endcase
  end

`ifdef PED_WALK_EN
  localparam logic [CW:0] Y_W = (CW+1)'(YELLOW_CYC);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= NS_LEFT;
      cnt            <= L_M1;
      save_state     <= NS_LEFT;
      save_cnt       <= '0;
      forced         <= 1'b0;
      pend           <= 1'b0;
      post           <= 1'b0;
      clr_ew         <= 1'b0;
      ns_out         <= 4'b1001;
      ew_out         <= 4'b0001;
      phase          <= 4'd0;
      preempt_active <= 1'b0;
`ifdef PED_WALK_EN
      ns_walk        <= 1'b0;
      ew_walk        <= 1'b0;
`endif
    end else begin
      state          <= n_state;
      cnt            <= n_cnt;
      save_state     <= n_save_state;
      save_cnt       <= n_save_cnt;
      forced         <= n_forced;
      pend           <= n_pend;
      post           <= n_post;
      clr_ew         <= n_clr_ew;
      ns_out         <= ns_lamp(n_state);
      ew_out         <= ew_lamp(n_state);
      phase          <= n_state;
      preempt_active <= (n_state == PREEMPT) || n_forced;
`ifdef PED_WALK_EN
      ns_walk        <= (n_state == NS_GREEN) && ({1'b0, n_cnt} >= Y_W);
      ew_walk        <= (n_state == EW_GREEN) && ({1'b0, n_cnt} >= Y_W);
`endif
    end
  end

endmodule
`default_nettype wire
